// File: rtl/ika9958_pkg.sv
// ----------------------------------------------------------------------------
// ika9958_pkg
// Shared types and constants for the IKA9958 CPU-side register controller.
//   port_e        : CPU port select (VRAM data, control, palette, indirect)
//   ctrl_state_e  : control-port two-byte sequence state
//   REG_PAL_PTR   : register index of the palette pointer (16)
//   REG_IND_PTR   : register index of the indirect-access pointer (17)
//   pal_entry_t   : one 9-bit palette entry, packed as {R3,B3,G3}
// ----------------------------------------------------------------------------
package ika9958_pkg;

    typedef enum logic [1:0] {
        PORT_VRAM = 2'd0,
        PORT_CTRL = 2'd1,
        PORT_PAL  = 2'd2,
        PORT_IND  = 2'd3
    } port_e;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LATCHED = 1'b1;

    typedef enum logic [0:0] {
        CTRL_IDLE    = ST_IDLE,
        CTRL_LATCHED = ST_LATCHED
    } ctrl_state_e;

    localparam logic [5:0] REG_PAL_PTR = 6'd16;
    localparam logic [5:0] REG_IND_PTR = 6'd17;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] b;
        logic [2:0] g;
    } pal_entry_t;

    // Indirect pointer index advance; wraps 63 -> 0 naturally in 6 bits.
    function automatic logic [5:0] ind_ptr_advance(input logic [5:0] ptr);
        return ptr + 6'd1;
    endfunction

endpackage

// File: rtl/ika9958_palseq.sv
// ----------------------------------------------------------------------------
// ika9958_palseq
// Two-byte palette write sequencer. The first write captures R and B, the
// second supplies G and issues one registered palette write at the current
// pointer, after which the pointer advances (mod 16). A pointer load (from a
// register-16 write) repositions the pointer and restarts the byte pair.
// Ports:
//   clk, srst            : clock, synchronous active-high reset
//   wr                   : palette-port write strobe (already decoded)
//   din_hi / din_lo      : write data bits [6:4] and [2:0]
//   ptr_load / ptr_data  : pointer load request and new pointer value
//   pal_we/addr/data     : registered palette write pulse, index, entry
// ----------------------------------------------------------------------------
module ika9958_palseq
    import ika9958_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       wr,
    input  logic [2:0] din_hi,
    input  logic [2:0] din_lo,
    input  logic       ptr_load,
    input  logic [3:0] ptr_data,
    output logic       pal_we,
    output logic [3:0] pal_addr,
    output logic [8:0] pal_data
);

    logic [3:0] ptr_reg;
    logic       second_reg;     // 1 = R/B captured, waiting for G
    logic [2:0] r_reg;
    logic [2:0] b_reg;
    logic       pal_we_reg;
    logic [3:0] pal_addr_reg;
    pal_entry_t pal_data_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg      <= 4'd0;
            second_reg   <= 1'b0;
            r_reg        <= 3'd0;
            b_reg        <= 3'd0;
            pal_we_reg   <= 1'b0;
            pal_addr_reg <= 4'd0;
            pal_data_reg <= '0;
        end else begin
            pal_we_reg <= 1'b0;
            if (ptr_load) begin
                ptr_reg    <= ptr_data;
                second_reg <= 1'b0;
            end else if (wr) begin
                if (!second_reg) begin
                    r_reg      <= din_hi;
                    b_reg      <= din_lo;
                    second_reg <= 1'b1;
                end else begin
                    pal_we_reg     <= 1'b1;
                    pal_addr_reg   <= ptr_reg;
                    pal_data_reg.r <= r_reg;
                    pal_data_reg.b <= b_reg;
                    pal_data_reg.g <= din_lo;
                    ptr_reg        <= ptr_reg + 4'd1;
                    second_reg     <= 1'b0;
                end
            end
        end
    end

    assign pal_we   = pal_we_reg;
    assign pal_addr = pal_addr_reg;
    assign pal_data = pal_data_reg;

endmodule

// File: rtl/ika9958_regctrl.sv
// ----------------------------------------------------------------------------
// ika9958_regctrl
// CPU-side register access controller for a V9958-style VDP.
//   Port 1 (control): two-byte sequence; second byte selects register write
//                     (bit7=1) or VRAM address setup (bit7=0). A port-1 read
//                     abandons a half-written sequence.
//   Port 3 (indirect): register write at R17[5:0]; R17 auto-increments unless
//                     R17[7] is set. Writes that would target R17 are dropped.
//   Port 2 (palette): two-byte palette write, only when the build macro
//                     IKA9958_PALETTE_PORT_EN is defined; otherwise ignored and
//                     the palette outputs are tied low.
// Ports:
//   i_EMUCLK, i_RST       : clock, synchronous active-high reset
//   i_WR, i_RD            : one-cycle CPU strobes (write has priority)
//   i_PORT, i_DIN         : port select, write data
//   o_REG_WE/ADDR/DATA    : registered register-file write
//   o_VADDR_SET/VADDR/WR  : registered VRAM address setup
//   o_PAL_WE/ADDR/DATA    : registered palette write
//   o_R17                 : indirect pointer shadow
// ----------------------------------------------------------------------------
module ika9958_regctrl
    import ika9958_pkg::*;
(
    input  logic        i_EMUCLK,
    input  logic        i_RST,
    input  logic        i_WR,
    input  logic        i_RD,
    input  logic [1:0]  i_PORT,
    input  logic [7:0]  i_DIN,
    output logic        o_REG_WE,
    output logic [5:0]  o_REG_ADDR,
    output logic [7:0]  o_REG_DATA,
    output logic        o_VADDR_SET,
    output logic [13:0] o_VADDR,
    output logic        o_VADDR_WR,
    output logic        o_PAL_WE,
    output logic [3:0]  o_PAL_ADDR,
    output logic [8:0]  o_PAL_DATA,
    output logic [7:0]  o_R17
);

    // Strobe decode; a simultaneous read is ignored when a write is present.
    logic wr_ctrl;
    logic rd_ctrl;
    logic wr_ind;

    assign wr_ctrl = i_WR && (i_PORT == PORT_CTRL);
    assign rd_ctrl = i_RD && !i_WR && (i_PORT == PORT_CTRL);
    assign wr_ind  = i_WR && (i_PORT == PORT_IND);

    ctrl_state_e state_reg,    state_next;
    logic [7:0]  latch_reg,    latch_next;
    logic [7:0]  r17_reg,      r17_next;
    logic        reg_we_reg,   reg_we_next;
    logic [5:0]  reg_addr_reg, reg_addr_next;
    logic [7:0]  reg_data_reg, reg_data_next;
    logic        vset_reg,     vset_next;
    logic [13:0] vaddr_reg,    vaddr_next;
    logic        vwr_reg,      vwr_next;

    always_comb begin
        state_next    = state_reg;
        latch_next    = latch_reg;
        r17_next      = r17_reg;
        reg_we_next   = 1'b0;
        reg_addr_next = reg_addr_reg;
        reg_data_next = reg_data_reg;
        vset_next     = 1'b0;
        vaddr_next    = vaddr_reg;
        vwr_next      = vwr_reg;

        if (wr_ctrl) begin
            if (state_reg == CTRL_IDLE) begin
                latch_next = i_DIN;
                state_next = CTRL_LATCHED;
            end else begin
                state_next = CTRL_IDLE;
                if (i_DIN[7]) begin
                    reg_we_next   = 1'b1;
                    reg_addr_next = i_DIN[5:0];
                    reg_data_next = latch_reg;
                end else begin
                    vset_next  = 1'b1;
                    vaddr_next = {i_DIN[5:0], latch_reg};
                    vwr_next   = i_DIN[6];
                end
            end
        end else if (rd_ctrl) begin
            // Abandon the sequence; the latch keeps its stale byte.
            state_next = CTRL_IDLE;
        end else if (wr_ind) begin
            // Indirect access must never rewrite its own pointer.
            if (r17_reg[5:0] != REG_IND_PTR) begin
                reg_we_next   = 1'b1;
                reg_addr_next = r17_reg[5:0];
                reg_data_next = i_DIN;
            end
            if (!r17_reg[7]) begin
                r17_next[5:0] = ind_ptr_advance(r17_reg[5:0]);
            end
        end

        // The shadow tracks the register file; only port 1 can reach R17.
        if (reg_we_next && (reg_addr_next == REG_IND_PTR)) begin
            r17_next = reg_data_next;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_reg    <= CTRL_IDLE;
            latch_reg    <= 8'd0;
            r17_reg      <= 8'd0;
            reg_we_reg   <= 1'b0;
            reg_addr_reg <= 6'd0;
            reg_data_reg <= 8'd0;
            vset_reg     <= 1'b0;
            vaddr_reg    <= 14'd0;
            vwr_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            latch_reg    <= latch_next;
            r17_reg      <= r17_next;
            reg_we_reg   <= reg_we_next;
            reg_addr_reg <= reg_addr_next;
            reg_data_reg <= reg_data_next;
            vset_reg     <= vset_next;
            vaddr_reg    <= vaddr_next;
            vwr_reg      <= vwr_next;
        end
    end

    assign o_REG_WE    = reg_we_reg;
    assign o_REG_ADDR  = reg_addr_reg;
    assign o_REG_DATA  = reg_data_reg;
    assign o_VADDR_SET = vset_reg;
    assign o_VADDR     = vaddr_reg;
    assign o_VADDR_WR  = vwr_reg;
    assign o_R17       = r17_reg;

`ifdef IKA9958_PALETTE_PORT_EN
    logic pal_wr;
    logic pal_ptr_load;

    assign pal_wr       = i_WR && (i_PORT == PORT_PAL);
    // Pointer reload is taken from the same decision that issues the R16 write.
    assign pal_ptr_load = reg_we_next && (reg_addr_next == REG_PAL_PTR);

    ika9958_palseq u_palseq (
        .clk      (i_EMUCLK),
        .srst     (i_RST),
        .wr       (pal_wr),
        .din_hi   (i_DIN[6:4]),
        .din_lo   (i_DIN[2:0]),
        .ptr_load (pal_ptr_load),
        .ptr_data (reg_data_next[3:0]),
        .pal_we   (o_PAL_WE),
        .pal_addr (o_PAL_ADDR),
        .pal_data (o_PAL_DATA)
    );
`else
    assign o_PAL_WE   = 1'b0;
    assign o_PAL_ADDR = 4'd0;
    assign o_PAL_DATA = 9'd0;
`endif

endmodule

// File: tb/tb_ika9958_regctrl.sv
// ----------------------------------------------------------------------------
// tb_ika9958_regctrl
// Directed scenarios followed by a randomized run checked against a
// transaction-level reference model (queues for the pending first bytes).
// Palette expectations follow the IKA9958_PALETTE_PORT_EN build macro.
// ----------------------------------------------------------------------------
module tb_ika9958_regctrl;

`ifdef IKA9958_PALETTE_PORT_EN
    localparam bit PAL_EN = 1'b1;
`else
    localparam bit PAL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wr;
    logic        rd;
    logic [1:0]  port;
    logic [7:0]  din;
    logic        reg_we;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        vset;
    logic [13:0] vaddr;
    logic        vwr;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [8:0]  pal_data;
    logic [7:0]  r17;

    int errors = 0;
    int checks = 0;

    ika9958_regctrl dut (
        .i_EMUCLK    (clk),
        .i_RST       (rst),
        .i_WR        (wr),
        .i_RD        (rd),
        .i_PORT      (port),
        .i_DIN       (din),
        .o_REG_WE    (reg_we),
        .o_REG_ADDR  (reg_addr),
        .o_REG_DATA  (reg_data),
        .o_VADDR_SET (vset),
        .o_VADDR     (vaddr),
        .o_VADDR_WR  (vwr),
        .o_PAL_WE    (pal_we),
        .o_PAL_ADDR  (pal_addr),
        .o_PAL_DATA  (pal_data),
        .o_R17       (r17)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_ctrl_q[$];   // pending first control byte (0 or 1 entries)
    logic [7:0]  m_pal_q[$];    // pending R/B palette byte (0 or 1 entries)
    logic [7:0]  m_r17;
    int          m_pal_ptr;
    logic        e_reg_we;
    logic [5:0]  e_reg_addr;
    logic [7:0]  e_reg_data;
    logic        e_vset;
    logic [13:0] e_vaddr;
    logic        e_vwr;
    logic        e_pal_we;
    logic [3:0]  e_pal_addr;
    logic [8:0]  e_pal_data;

    task automatic model_regwrite(input int a, input logic [7:0] d);
        e_reg_we   = 1'b1;
        e_reg_addr = 6'(a);
        e_reg_data = d;
        if (a == 17) m_r17 = d;
        if (a == 16 && PAL_EN) begin
            m_pal_ptr = int'(d) % 16;
            m_pal_q.delete();
        end
    endtask

    task automatic model_update(input bit r, input bit w, input bit rdi,
                                input bit [1:0] p, input logic [7:0] d);
        logic [7:0] first;
        int a;
        e_reg_we = 1'b0;
        e_vset   = 1'b0;
        e_pal_we = 1'b0;
        if (r) begin
            m_ctrl_q.delete();
            m_pal_q.delete();
            m_r17 = 8'd0; m_pal_ptr = 0;
            e_reg_addr = '0; e_reg_data = '0; e_vaddr = '0; e_vwr = 1'b0;
            e_pal_addr = '0; e_pal_data = '0;
        end else if (w) begin
            case (p)
                2'd1: begin
                    if (m_ctrl_q.size() == 0) m_ctrl_q.push_back(d);
                    else begin
                        first = m_ctrl_q.pop_front();
                        if (d[7]) model_regwrite(int'(d[5:0]), first);
                        else begin
                            e_vset  = 1'b1;
                            e_vaddr = {d[5:0], first};
                            e_vwr   = d[6];
                        end
                    end
                end
                2'd2: begin
                    if (PAL_EN) begin
                        if (m_pal_q.size() == 0) m_pal_q.push_back(d);
                        else begin
                            first      = m_pal_q.pop_front();
                            e_pal_we   = 1'b1;
                            e_pal_addr = 4'(m_pal_ptr);
                            e_pal_data = {first[6:4], first[2:0], d[2:0]};
                            m_pal_ptr  = (m_pal_ptr + 1) % 16;
                        end
                    end
                end
                2'd3: begin
                    a = int'(m_r17) % 64;
                    if (a != 17) model_regwrite(a, d);
                    if (m_r17 < 8'd128) m_r17 = (m_r17 & 8'hC0) | 8'((a + 1) % 64);
                end
                default: ;
            endcase
        end else if (rdi && p == 2'd1) begin
            m_ctrl_q.delete();
        end
    endtask

    // One clock cycle: present inputs, sample outputs 1 time unit after edge.
    task automatic step(input bit r, input bit w, input bit rdi,
                        input bit [1:0] p, input logic [7:0] d);
        rst = r; wr = w; rd = rdi; port = p; din = d;
        @(posedge clk);
        #1;
        model_update(r, w, rdi, p, d);
        $display("txn rst=%0b wr=%0b rd=%0b port=%0d din=%02h -> we=%0b a=%0d d=%02h vs=%0b va=%04h vw=%0b pw=%0b pa=%0d pd=%03h r17=%02h",
                 r, w, rdi, p, d, reg_we, reg_addr, reg_data, vset, vaddr, vwr,
                 pal_we, pal_addr, pal_data, r17);
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(1, 1, 0, 2'd1, 8'hFF);
        step(1, 1, 0, 2'd3, 8'hEE);
        checks++; if (reg_we   !== 1'b0)  begin errors++; $display("FAIL rst_reg_we got=%0b want=0", reg_we); end
        checks++; if (reg_addr !== 6'd0)  begin errors++; $display("FAIL rst_reg_addr got=%0d want=0", reg_addr); end
        checks++; if (reg_data !== 8'd0)  begin errors++; $display("FAIL rst_reg_data got=%02h want=00", reg_data); end
        checks++; if (vset     !== 1'b0)  begin errors++; $display("FAIL rst_vset got=%0b want=0", vset); end
        checks++; if (vaddr    !== 14'd0) begin errors++; $display("FAIL rst_vaddr got=%04h want=0000", vaddr); end
        checks++; if (vwr      !== 1'b0)  begin errors++; $display("FAIL rst_vwr got=%0b want=0", vwr); end
        checks++; if (pal_we   !== 1'b0)  begin errors++; $display("FAIL rst_pal_we got=%0b want=0", pal_we); end
        checks++; if (pal_addr !== 4'd0)  begin errors++; $display("FAIL rst_pal_addr got=%0d want=0", pal_addr); end
        checks++; if (pal_data !== 9'd0)  begin errors++; $display("FAIL rst_pal_data got=%03h want=000", pal_data); end
        checks++; if (r17      !== 8'd0)  begin errors++; $display("FAIL rst_r17 got=%02h want=00", r17); end
        step(0, 0, 0, 2'd0, 8'h00);
    endtask

    task automatic test_reg_write();
        step(0, 1, 0, 2'd1, 8'h5A);
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL regwr_first_we got=%0b want=0", reg_we); end
        step(0, 1, 0, 2'd1, 8'h87);
        checks++; if (reg_we   !== 1'b1)  begin errors++; $display("FAIL regwr_we got=%0b want=1", reg_we); end
        checks++; if (reg_addr !== 6'd7)  begin errors++; $display("FAIL regwr_addr got=%0d want=7", reg_addr); end
        checks++; if (reg_data !== 8'h5A) begin errors++; $display("FAIL regwr_data got=%02h want=5a", reg_data); end
        step(0, 0, 0, 2'd0, 8'h00);
        checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL regwr_pulse_len got=%0b want=0", reg_we); end
        // Back in IDLE: a fresh pair writes R0.
        step(0, 1, 0, 2'd1, 8'h01);
        step(0, 1, 0, 2'd1, 8'h80);
        checks++; if (reg_we !== 1'b1 || reg_addr !== 6'd0 || reg_data !== 8'h01) begin
            errors++; $display("FAIL regwr_idle got=%0b/%0d/%02h want=1/0/01", reg_we, reg_addr, reg_data); end
    endtask

    task automatic test_addr_setup();
        step(0, 1, 0, 2'd1, 8'h34);
        step(0, 1, 0, 2'd1, 8'h52);
        checks++; if (vset  !== 1'b1)     begin errors++; $display("FAIL vaddr_set got=%0b want=1", vset); end
        checks++; if (vaddr !== 14'h1234) begin errors++; $display("FAIL vaddr_val got=%04h want=1234", vaddr); end
        checks++; if (vwr   !== 1'b1)     begin errors++; $display("FAIL vaddr_wr got=%0b want=1", vwr); end
        checks++; if (reg_we !== 1'b0)    begin errors++; $display("FAIL vaddr_no_regwe got=%0b want=0", reg_we); end
        step(0, 1, 0, 2'd1, 8'hCD);
        step(0, 1, 0, 2'd1, 8'h2B);
        checks++; if (vset !== 1'b1 || vaddr !== 14'h2BCD || vwr !== 1'b0) begin
            errors++; $display("FAIL vaddr_read got=%0b/%04h/%0b want=1/2bcd/0", vset, vaddr, vwr); end
    endtask

    task automatic test_read_abort();
        step(0, 1, 0, 2'd1, 8'h11);
        step(0, 0, 1, 2'd1, 8'h00);
        step(0, 1, 0, 2'd1, 8'h22);
        checks++; if (reg_we !== 1'b0 || vset !== 1'b0) begin
            errors++; $display("FAIL abort_no_out got=%0b/%0b want=0/0", reg_we, vset); end
        step(0, 1, 0, 2'd1, 8'h83);
        checks++; if (reg_we !== 1'b1 || reg_addr !== 6'd3 || reg_data !== 8'h22) begin
            errors++; $display("FAIL abort_write got=%0b/%0d/%02h want=1/3/22", reg_we, reg_addr, reg_data); end
        // Port-0 and port-3 reads leave the latched state alone; write wins over read.
        step(0, 1, 0, 2'd1, 8'h44);
        step(0, 0, 1, 2'd0, 8'h00);
        step(0, 1, 0, 2'd0, 8'h99);
        step(0, 0, 1, 2'd3, 8'h00);
        step(0, 1, 1, 2'd1, 8'h85);
        checks++; if (reg_we !== 1'b1 || reg_addr !== 6'd5 || reg_data !== 8'h44) begin
            errors++; $display("FAIL wr_over_rd got=%0b/%0d/%02h want=1/5/44", reg_we, reg_addr, reg_data); end
    endtask

    task automatic test_indirect();
        step(0, 1, 0, 2'd1, 8'h3F);
        step(0, 1, 0, 2'd1, 8'h91);
        checks++; if (r17 !== 8'h3F || reg_we !== 1'b1) begin
            errors++; $display("FAIL ind_load got=%02h/%0b want=3f/1", r17, reg_we); end
        step(0, 1, 0, 2'd3, 8'hAA);
        checks++; if (reg_we !== 1'b1 || reg_addr !== 6'd63 || reg_data !== 8'hAA) begin
            errors++; $display("FAIL ind_w63 got=%0b/%0d/%02h want=1/63/aa", reg_we, reg_addr, reg_data); end
        step(0, 1, 0, 2'd3, 8'hBB);
        checks++; if (reg_we !== 1'b1 || reg_addr !== 6'd0 || reg_data !== 8'hBB) begin
            errors++; $display("FAIL ind_w0 got=%0b/%0d/%02h want=1/0/bb", reg_we, reg_addr, reg_data); end
        checks++; if (r17 !== 8'h01) begin errors++; $display("FAIL ind_r17 got=%02h want=01", r17); end
        // Pointer at 17 with auto-increment off: both writes dropped, pointer frozen.
        step(0, 1, 0, 2'd1, 8'h91);
        step(0, 1, 0, 2'd1, 8'h91);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 2'd3, 8'hCC);
            checks++; if (reg_we !== 1'b0 || r17 !== 8'h91) begin
                errors++; $display("FAIL ind_suppress%0d got=%0b/%02h want=0/91", i, reg_we, r17); end
        end
        // Pointer at 17 with auto-increment on: write dropped, pointer still moves; bit6 kept.
        step(0, 1, 0, 2'd1, 8'h51);
        step(0, 1, 0, 2'd1, 8'h91);
        step(0, 1, 0, 2'd3, 8'h77);
        checks++; if (reg_we !== 1'b0 || r17 !== 8'h52) begin
            errors++; $display("FAIL ind_supp_inc got=%0b/%02h want=0/52", reg_we, r17); end
    endtask

    task automatic test_palette();
`ifdef IKA9958_PALETTE_PORT_EN
        step(0, 1, 0, 2'd1, 8'h0F);
        step(0, 1, 0, 2'd1, 8'h90);
        step(0, 1, 0, 2'd2, 8'h72);
        checks++; if (pal_we !== 1'b0) begin errors++; $display("FAIL pal_first got=%0b want=0", pal_we); end
        step(0, 1, 0, 2'd2, 8'h05);
        checks++; if (pal_we !== 1'b1 || pal_addr !== 4'd15 || pal_data !== 9'b111_010_101) begin
            errors++; $display("FAIL pal_w15 got=%0b/%0d/%03h want=1/15/1d5", pal_we, pal_addr, pal_data); end
        // Port-1 traffic between palette bytes does not disturb the pair; pointer wrapped.
        step(0, 1, 0, 2'd2, 8'h31);
        step(0, 1, 0, 2'd1, 8'h12);
        step(0, 1, 0, 2'd2, 8'h06);
        checks++; if (pal_we !== 1'b1 || pal_addr !== 4'd0 || pal_data !== 9'b011_001_110) begin
            errors++; $display("FAIL pal_wrap got=%0b/%0d/%03h want=1/0/0ce", pal_we, pal_addr, pal_data); end
        step(0, 0, 0, 2'd0, 8'h00);
`else
        step(0, 1, 0, 2'd2, 8'h72);
        step(0, 1, 0, 2'd2, 8'h05);
        checks++; if (pal_we !== 1'b0 || pal_addr !== 4'd0 || pal_data !== 9'd0) begin
            errors++; $display("FAIL pal_tied got=%0b/%0d/%03h want=0/0/000", pal_we, pal_addr, pal_data); end
`endif
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0, 2'd1, 8'hAA);
        step(0, 1, 0, 2'd2, 8'h77);
        step(1, 1, 0, 2'd1, 8'h99);
        step(0, 1, 0, 2'd1, 8'h55);
        checks++; if (vset !== 1'b0 || reg_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_discard got=%0b/%0b want=0/0", vset, reg_we); end
        step(0, 1, 0, 2'd1, 8'h81);
        checks++; if (reg_we !== 1'b1 || reg_addr !== 6'd1 || reg_data !== 8'h55) begin
            errors++; $display("FAIL rstmid_write got=%0b/%0d/%02h want=1/1/55", reg_we, reg_addr, reg_data); end
`ifdef IKA9958_PALETTE_PORT_EN
        step(0, 1, 0, 2'd2, 8'h12);
        checks++; if (pal_we !== 1'b0) begin errors++; $display("FAIL rstmid_pal got=%0b want=0", pal_we); end
        step(0, 1, 0, 2'd2, 8'h03);
        checks++; if (pal_we !== 1'b1 || pal_addr !== 4'd0 || pal_data !== 9'b001_010_011) begin
            errors++; $display("FAIL rstmid_palwr got=%0b/%0d/%03h want=1/0/053", pal_we, pal_addr, pal_data); end
`endif
    endtask

    task automatic test_back_to_back();
        step(0, 1, 0, 2'd1, 8'h20);
        step(0, 1, 0, 2'd1, 8'h91);
        step(0, 1, 0, 2'd3, 8'h01);
        checks++; if (reg_we !== 1'b1 || reg_addr !== 6'd32 || reg_data !== 8'h01) begin
            errors++; $display("FAIL b2b_0 got=%0b/%0d/%02h want=1/32/01", reg_we, reg_addr, reg_data); end
        step(0, 1, 0, 2'd3, 8'h02);
        checks++; if (reg_we !== 1'b1 || reg_addr !== 6'd33 || reg_data !== 8'h02) begin
            errors++; $display("FAIL b2b_1 got=%0b/%0d/%02h want=1/33/02", reg_we, reg_addr, reg_data); end
        step(0, 1, 0, 2'd1, 8'hEF);
        step(0, 1, 0, 2'd1, 8'h7F);
        checks++; if (vset !== 1'b1 || vaddr !== 14'h3FEF || vwr !== 1'b1 || reg_we !== 1'b0) begin
            errors++; $display("FAIL b2b_vaddr got=%0b/%04h/%0b/%0b want=1/3fef/1/0", vset, vaddr, vwr, reg_we); end
        step(0, 1, 0, 2'd3, 8'h03);
        checks++; if (vset !== 1'b0 || reg_addr !== 6'd34 || r17 !== 8'h23) begin
            errors++; $display("FAIL b2b_2 got=%0b/%0d/%02h want=0/34/23", vset, reg_addr, r17); end
    endtask

    task automatic test_random();
        bit r, w, rdi;
        bit [1:0] p;
        logic [7:0] d;
        for (int n = 0; n < 2500; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            w   = ($urandom_range(0, 2) != 0);
            rdi = ($urandom_range(0, 3) == 0);
            p   = 2'($urandom_range(0, 3));
            d   = 8'($urandom);
            step(r, w, rdi, p, d);
            checks++; if (reg_we   !== e_reg_we)   begin errors++; $display("FAIL rnd%0d_reg_we got=%0b want=%0b", n, reg_we, e_reg_we); end
            checks++; if (reg_addr !== e_reg_addr) begin errors++; $display("FAIL rnd%0d_reg_addr got=%0d want=%0d", n, reg_addr, e_reg_addr); end
            checks++; if (reg_data !== e_reg_data) begin errors++; $display("FAIL rnd%0d_reg_data got=%02h want=%02h", n, reg_data, e_reg_data); end
            checks++; if (vset     !== e_vset)     begin errors++; $display("FAIL rnd%0d_vset got=%0b want=%0b", n, vset, e_vset); end
            checks++; if (vaddr    !== e_vaddr)    begin errors++; $display("FAIL rnd%0d_vaddr got=%04h want=%04h", n, vaddr, e_vaddr); end
            checks++; if (vwr      !== e_vwr)      begin errors++; $display("FAIL rnd%0d_vwr got=%0b want=%0b", n, vwr, e_vwr); end
            checks++; if (pal_we   !== e_pal_we)   begin errors++; $display("FAIL rnd%0d_pal_we got=%0b want=%0b", n, pal_we, e_pal_we); end
            checks++; if (pal_addr !== e_pal_addr) begin errors++; $display("FAIL rnd%0d_pal_addr got=%0d want=%0d", n, pal_addr, e_pal_addr); end
            checks++; if (pal_data !== e_pal_data) begin errors++; $display("FAIL rnd%0d_pal_data got=%03h want=%03h", n, pal_data, e_pal_data); end
            checks++; if (r17      !== m_r17)      begin errors++; $display("FAIL rnd%0d_r17 got=%02h want=%02h", n, r17, m_r17); end
        end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; port = 2'd0; din = 8'd0;
        test_reset();
        test_reg_write();
        test_addr_setup();
        test_read_abort();
        test_indirect();
        test_palette();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
